// File: rtl/pipelined_control_unit.sv
// Pipelined MIPS control unit: decodes the ID instruction into a registered ID/EX
// control bundle, with load-use stall, branch flush, EX-busy hold and JR forwarding.
module pipelined_control_unit #(
  parameter int ALUOP_W   = 4,
  parameter int REG_W     = 5,
  parameter int FWD_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic [REG_W-1:0]   rd,
  input  logic               branch_taken,
  input  logic               ex_busy,
  output logic               ex_valid,
  output logic               RegWrite,
  output logic               MemToReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic               RegDst,
  output logic               ALUSrc,
  output logic               Link,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [REG_W-1:0]   ex_dest,
  output logic [1:0]         jump,
  output logic [1:0]         jr_fwd_sel,
  output logic               pc_stall,
  output logic               ifid_flush,
  output logic               illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               reg_dst;
    logic               alu_src;
    logic               link;
    logic [ALUOP_W-1:0] alu_op;
    logic [REG_W-1:0]   dest;
    logic [1:0]         jump;
    logic [1:0]         fwd_sel;
  } bundle_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_read;
    logic [REG_W-1:0] dest;
  } hist_t;

  bundle_t                    ctrl_q, ctrl_d, dec, issue;
  hist_t   [FWD_DEPTH-1:0]    hist_q, hist_d;
  logic                       illegal_q, illegal_d;
  logic                       legal, uses_rt, is_jr, is_jmp;
  logic                       fwd_hit, load_use, jr_load, hazard, accept;
  logic [1:0]                 fwd_idx;

  // Instruction decode; non-writing instructions carry dest 0 so they never alias a hazard.
  always_comb begin
    dec     = '0;
    legal   = 1'b1;
    uses_rt = 1'b0;
    is_jr   = 1'b0;
    is_jmp  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt       = 1'b1;
        dec.reg_write = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_op = ALUOP_W'(4'b0001);
          FN_ADDU: dec.alu_op = ALUOP_W'(4'b1010);
          FN_SUB:  dec.alu_op = ALUOP_W'(4'b0010);
          FN_SUBU: dec.alu_op = ALUOP_W'(4'b1011);
          FN_AND:  dec.alu_op = ALUOP_W'(4'b0011);
          FN_OR:   dec.alu_op = ALUOP_W'(4'b0100);
          FN_NOR:  dec.alu_op = ALUOP_W'(4'b0101);
          FN_SLT:  dec.alu_op = ALUOP_W'(4'b0110);
          FN_SLL:  dec.alu_op = ALUOP_W'(4'b0111);
          FN_SRL:  dec.alu_op = ALUOP_W'(4'b1000);
          FN_SRA:  dec.alu_op = ALUOP_W'(4'b1001);
          FN_JR: begin
            dec.reg_write = 1'b0;
            is_jr         = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ANDI, OP_ORI, OP_SLTI, OP_ADDI, OP_ADDIU, OP_LUI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        case (opcode)
          OP_ANDI:  dec.alu_op = ALUOP_W'(4'b0011);
          OP_ORI:   dec.alu_op = ALUOP_W'(4'b0100);
          OP_SLTI:  dec.alu_op = ALUOP_W'(4'b0110);
          OP_ADDI:  dec.alu_op = ALUOP_W'(4'b0001);
          OP_ADDIU: dec.alu_op = ALUOP_W'(4'b1010);
          default:  dec.alu_op = ALUOP_W'(4'b1111);
        endcase
      end
      OP_BEQ, OP_BNE, OP_BGTZ, OP_BGEZ: begin
        dec.branch = 1'b1;
        uses_rt    = (opcode == OP_BEQ) || (opcode == OP_BNE);
        case (opcode)
          OP_BEQ:  dec.alu_op = ALUOP_W'(4'b0010);
          OP_BNE:  dec.alu_op = ALUOP_W'(4'b1110);
          OP_BGTZ: dec.alu_op = ALUOP_W'(4'b1100);
          default: dec.alu_op = ALUOP_W'(4'b1101);
        endcase
      end
      OP_LW: begin
        dec.alu_op     = ALUOP_W'(4'b0001);
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.reg_dst    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        uses_rt       = 1'b1;
        dec.alu_op    = ALUOP_W'(4'b0001);
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_J: begin
        is_jmp   = 1'b1;
        dec.jump = 2'b11;
      end
      OP_JAL: begin
        is_jmp        = 1'b1;
        dec.jump      = 2'b11;
        dec.link      = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    dec.valid = legal;
    if (dec.reg_write) begin
      dec.dest = dec.link ? REG_W'(31) : (dec.reg_dst ? rt : rd);
    end
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_idx = 2'b00;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (hist_q[i].reg_write && (hist_q[i].dest == rs) && (rs != '0)) begin
        fwd_hit = 1'b1;
        fwd_idx = 2'(i);
      end
    end
  end

  always_comb begin
    issue = dec;
    if (is_jr) begin
      issue.jump    = fwd_hit ? 2'b10 : 2'b01;
      issue.fwd_sel = fwd_hit ? fwd_idx : 2'b00;
    end
  end

  assign load_use = ctrl_q.valid && ctrl_q.mem_read && (ctrl_q.dest != '0) &&
                    ((ctrl_q.dest == rs) || (uses_rt && (ctrl_q.dest == rt)));
  assign jr_load  = is_jr && fwd_hit && (fwd_idx == 2'b00) && hist_q[0].mem_read;
  assign hazard   = instr_valid && (load_use || jr_load);

  // Pipeline control in priority order: reset, branch flush, EX busy, hazard, issue.
  always_comb begin
    pc_stall   = 1'b0;
    ifid_flush = 1'b0;
    accept     = 1'b0;
    if (rst) begin
      pc_stall = 1'b0;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
    end else if (ex_busy || hazard) begin
      pc_stall = 1'b1;
    end else if (instr_valid) begin
      accept     = 1'b1;
      ifid_flush = legal && is_jmp;
    end
  end

  always_comb begin
    ctrl_d    = '0;
    illegal_d = 1'b0;
    hist_d    = hist_q;
    if (ex_busy && !branch_taken) begin
      ctrl_d = ctrl_q;
    end else begin
      if (accept && legal) begin
        ctrl_d = issue;
      end
      illegal_d = accept && !legal;
      for (int i = 1; i < FWD_DEPTH; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      hist_d[0] = {ctrl_d.reg_write, ctrl_d.mem_read, ctrl_d.dest};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      hist_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      hist_q    <= hist_d;
      illegal_q <= illegal_d;
    end
  end

  assign ex_valid   = ctrl_q.valid;
  assign RegWrite   = ctrl_q.reg_write;
  assign MemToReg   = ctrl_q.mem_to_reg;
  assign MemRead    = ctrl_q.mem_read;
  assign MemWrite   = ctrl_q.mem_write;
  assign Branch     = ctrl_q.branch;
  assign RegDst     = ctrl_q.reg_dst;
  assign ALUSrc     = ctrl_q.alu_src;
  assign Link       = ctrl_q.link;
  assign ALUOp      = ctrl_q.alu_op;
  assign ex_dest    = ctrl_q.dest;
  assign jump       = ctrl_q.jump;
  assign jr_fwd_sel = ctrl_q.fwd_sel;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: a cycle-by-cycle vector table plus
// hand-written sequences for flush priority, EX-busy hold and reset during a stall.
module tb_pipelined_control_unit;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       bt;
    logic       busy;
    logic       e_stall;
    logic       e_flush;
    logic [8:0] e_flags;
    logic [3:0] e_alu;
    logic [4:0] e_dest;
    logic [1:0] e_jump;
    logic [1:0] e_sel;
    logic       e_ill;
  } vec_t;

  // {ex_valid, RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc, Link}
  localparam logic [8:0] FL_NONE = 9'b000000000;
  localparam logic [8:0] FL_R    = 9'b110000000;
  localparam logic [8:0] FL_IMM  = 9'b110000110;
  localparam logic [8:0] FL_LW   = 9'b111100110;
  localparam logic [8:0] FL_SW   = 9'b100010010;
  localparam logic [8:0] FL_BR   = 9'b100001000;
  localparam logic [8:0] FL_JMP  = 9'b100000000;
  localparam logic [8:0] FL_JAL  = 9'b110000001;

  localparam logic [5:0] R = 6'b000000;

  logic       clk, rst, instr_valid, branch_taken, ex_busy;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       ex_valid, RegWrite, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUSrc, Link;
  logic [3:0] ALUOp;
  logic [4:0] ex_dest;
  logic [1:0] jump, jr_fwd_sel;
  logic       pc_stall, ifid_flush, illegal_op;

  int n_compared   = 0;
  int n_mismatched = 0;
  int vec_idx      = 0;

  pipelined_control_unit #(.ALUOP_W(4), .REG_W(5), .FWD_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .branch_taken(branch_taken), .ex_busy(ex_busy),
    .ex_valid(ex_valid), .RegWrite(RegWrite), .MemToReg(MemToReg), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .RegDst(RegDst), .ALUSrc(ALUSrc), .Link(Link),
    .ALUOp(ALUOp), .ex_dest(ex_dest), .jump(jump), .jr_fwd_sel(jr_fwd_sel),
    .pc_stall(pc_stall), .ifid_flush(ifid_flush), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic v, input logic [5:0] op,
                              input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] d, input logic b, input logic bz,
                              input logic es, input logic ef, input logic [8:0] fl,
                              input logic [3:0] alu, input logic [4:0] dst,
                              input logic [1:0] jmp, input logic [1:0] sel, input logic ill);
    vec_t x;
    x = '{r, v, op, fn, s, t, d, b, bz, es, ef, fl, alu, dst, jmp, sel, ill};
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL v%0d %s: got %0h expected %0h", vec_idx, name, got, exp);
    end
  endtask

  // Drive one ID cycle, check the combinational controls, then the registered bundle.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; instr_valid = v.valid; opcode = v.op; funct = v.fn;
    rs = v.rs; rt = v.rt; rd = v.rd; branch_taken = v.bt; ex_busy = v.busy;
    #1;
    checkOutput("pc_stall", 32'(pc_stall), 32'(v.e_stall));
    checkOutput("ifid_flush", 32'(ifid_flush), 32'(v.e_flush));
    @(posedge clk);
    #1;
    checkOutput("flags", 32'({ex_valid, RegWrite, MemToReg, MemRead, MemWrite, Branch,
                              RegDst, ALUSrc, Link}), 32'(v.e_flags));
    checkOutput("ALUOp", 32'(ALUOp), 32'(v.e_alu));
    checkOutput("ex_dest", 32'(ex_dest), 32'(v.e_dest));
    checkOutput("jump", 32'(jump), 32'(v.e_jump));
    checkOutput("jr_fwd_sel", 32'(jr_fwd_sel), 32'(v.e_sel));
    checkOutput("illegal_op", 32'(illegal_op), 32'(v.e_ill));
    vec_idx++;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; instr_valid = 1'b0; opcode = '0; funct = '0;
    rs = '0; rt = '0; rd = '0; branch_taken = 1'b0; ex_busy = 1'b0;

    //           rst v  op         fn         rs  rt  rd  bt bz st fl  flags    alu      dst jmp    sel    ill
    tbl.push_back(mk(1, 0, R,         6'h00,     0,  0,  0,  0, 0, 0, 0, FL_NONE, 4'b0000, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b100000, 1,  2,  3,  0, 0, 0, 0, FL_R,    4'b0001, 3,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b100011, 6'h00,     1,  5,  0,  0, 0, 0, 0, FL_LW,   4'b0001, 5,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b100000, 5,  2,  6,  0, 0, 1, 0, FL_NONE, 4'b0000, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b100000, 5,  2,  6,  0, 0, 0, 0, FL_R,    4'b0001, 6,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b001000, 6'h04,     0,  8,  0,  0, 0, 0, 0, FL_IMM,  4'b0001, 8,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b001000, 8,  0,  0,  0, 0, 0, 0, FL_JMP,  4'b0000, 0,  2'b10, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b001000, 6'h04,     0,  8,  0,  0, 0, 0, 0, FL_IMM,  4'b0001, 8,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 0, R,         6'h00,     0,  0,  0,  0, 0, 0, 0, FL_NONE, 4'b0000, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b001000, 8,  0,  0,  0, 0, 0, 0, FL_JMP,  4'b0000, 0,  2'b10, 2'b01, 0));
    tbl.push_back(mk(0, 1, 6'b001000, 6'h04,     0,  8,  0,  0, 0, 0, 0, FL_IMM,  4'b0001, 8,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 0, R,         6'h00,     0,  0,  0,  0, 0, 0, 0, FL_NONE, 4'b0000, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 0, R,         6'h00,     0,  0,  0,  0, 0, 0, 0, FL_NONE, 4'b0000, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b001000, 8,  0,  0,  0, 0, 0, 0, FL_JMP,  4'b0000, 0,  2'b01, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b100011, 6'h00,     1,  0,  0,  0, 0, 0, 0, FL_LW,   4'b0001, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b001000, 0,  0,  0,  0, 0, 0, 0, FL_JMP,  4'b0000, 0,  2'b01, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b100011, 6'h00,     1,  9,  0,  0, 0, 0, 0, FL_LW,   4'b0001, 9,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b001000, 9,  0,  0,  0, 0, 1, 0, FL_NONE, 4'b0000, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b001000, 9,  0,  0,  0, 0, 0, 0, FL_JMP,  4'b0000, 0,  2'b10, 2'b01, 0));
    tbl.push_back(mk(0, 1, 6'b111111, 6'h00,     0,  0,  0,  0, 0, 0, 0, FL_NONE, 4'b0000, 0,  2'b00, 2'b00, 1));
    tbl.push_back(mk(0, 0, R,         6'h00,     0,  0,  0,  0, 0, 0, 0, FL_NONE, 4'b0000, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b000010, 6'h00,     0,  0,  0,  0, 0, 0, 1, FL_JMP,  4'b0000, 0,  2'b11, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b000011, 6'h00,     0,  0,  0,  0, 0, 0, 1, FL_JAL,  4'b0000, 31, 2'b11, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b101011, 6'h00,     1,  2,  0,  0, 0, 0, 0, FL_SW,   4'b0001, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b000100, 6'h00,     1,  2,  0,  0, 0, 0, 0, FL_BR,   4'b0010, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b000101, 6'h00,     1,  2,  0,  0, 0, 0, 0, FL_BR,   4'b1110, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b000111, 6'h00,     1,  0,  0,  0, 0, 0, 0, FL_BR,   4'b1100, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b000001, 6'h00,     1,  1,  0,  0, 0, 0, 0, FL_BR,   4'b1101, 0,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b100010, 1,  2,  4,  0, 0, 0, 0, FL_R,    4'b0010, 4,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, 6'b001111, 6'h00,     0,  7,  0,  0, 0, 0, 0, FL_IMM,  4'b1111, 7,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b101010, 1,  2,  9,  0, 0, 0, 0, FL_R,    4'b0110, 9,  2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b100111, 1,  2,  11, 0, 0, 0, 0, FL_R,    4'b0101, 11, 2'b00, 2'b00, 0));
    tbl.push_back(mk(0, 1, R,         6'b000000, 0,  2,  10, 0, 0, 0, 0, FL_R,    4'b0111, 10, 2'b00, 2'b00, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
    end

    $display("[TB] branch_taken over ex_busy and load-use");
    applyStimulus(mk(0, 1, 6'b100011, 6'h00,     1,  5,  0,  0, 0, 0, 0, FL_LW,   4'b0001, 5,  2'b00, 2'b00, 0));
    applyStimulus(mk(0, 1, R,         6'b100000, 5,  2,  6,  1, 1, 0, 1, FL_NONE, 4'b0000, 0,  2'b00, 2'b00, 0));

    $display("[TB] ex_busy holds the ID/EX bundle");
    applyStimulus(mk(0, 1, R,         6'b100000, 1,  2,  3,  0, 0, 0, 0, FL_R,    4'b0001, 3,  2'b00, 2'b00, 0));
    applyStimulus(mk(0, 1, 6'b001000, 6'h04,     0,  8,  0,  0, 1, 1, 0, FL_R,    4'b0001, 3,  2'b00, 2'b00, 0));
    applyStimulus(mk(0, 1, 6'b001000, 6'h04,     0,  8,  0,  0, 0, 0, 0, FL_IMM,  4'b0001, 8,  2'b00, 2'b00, 0));

    $display("[TB] reset during a load-use stall clears bundle and history");
    applyStimulus(mk(0, 1, 6'b100011, 6'h00,     1,  8,  0,  0, 0, 0, 0, FL_LW,   4'b0001, 8,  2'b00, 2'b00, 0));
    applyStimulus(mk(1, 1, R,         6'b100000, 8,  2,  6,  0, 0, 0, 0, FL_NONE, 4'b0000, 0,  2'b00, 2'b00, 0));
    applyStimulus(mk(0, 1, R,         6'b001000, 8,  0,  0,  0, 0, 0, 0, FL_JMP,  4'b0000, 0,  2'b01, 2'b00, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
